// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PROM address, waits out access time,
// captures the word into a one-entry output register with valid/ready handoff.
module fetch_unit #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] ain,
  output logic        oen,
  input  logic [15:0] din,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [15:0] branch_target
);

  localparam int unsigned AW    = 16;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    ain_q, ain_d;
  logic             oen_q, oen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    instr_q, instr_d;
  logic [AW-1:0]    instr_pc_q, instr_pc_d;
  logic             valid_q, valid_d;

  logic transfer_c;
  logic slot_free_c;
  logic capture_c;

  assign transfer_c  = valid_q & instr_ready;
  assign slot_free_c = ~valid_q | transfer_c;

  // Next-state: sequencing first, then capture, then branch overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ain_d      = ain_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    capture_c  = 1'b0;

    if (transfer_c) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_ACCESS;
        ain_d   = pc_q;
        cnt_d   = CNT_RELOAD;
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (slot_free_c) begin
          capture_c = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Address has been stable since the wait expired, so data is good now.
        if (slot_free_c) begin
          capture_c = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture_c) begin
      state_d    = S_ACCESS;
      instr_d    = din;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + AW'(1);
      ain_d      = pc_q + AW'(1);
      cnt_d      = CNT_RELOAD;
    end

    if (branch_en) begin
      state_d    = S_ACCESS;
      pc_d       = branch_target;
      ain_d      = branch_target;
      cnt_d      = CNT_RELOAD;
      valid_d    = 1'b0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end

    oen_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ain_q      <= RESET_PC;
      oen_q      <= 1'b1;
      cnt_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ain_q      <= ain_d;
      oen_q      <= oen_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign ain         = ain_q;
  assign oen         = oen_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with fixed expectations, then a
// randomized run checked against a transaction-level scoreboard of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned W = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] ain;
  logic        oen;
  logic [15:0] din;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [15:0] branch_target;

  logic [15:0] mem [0:65535];
  int checks;
  int errors;

  assign din = mem[ain];

  fetch_unit #(.WAIT_CYCLES(W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .ain(ain), .oen(oen), .din(din),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_en(branch_en), .branch_target(branch_target)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Hold reset for one clock and release at a negedge; next posedge is edge 1.
  task automatic restart(input logic rdy);
    rst_n = 1'b0;
    branch_en = 1'b0;
    branch_target = 16'h0000;
    tick();
    instr_ready = rdy;
    rst_n = 1'b1;
  endtask

  // Expects reset just released with instr_ready=1; observes edges 1..10.
  task automatic check_stream(input string name);
    logic [15:0] exp_w [3];
    logic [15:0] exp_ain;
    logic [15:0] exp_i;
    logic [15:0] exp_p;
    logic        exp_v;
    exp_w[0] = 16'hF000; exp_w[1] = 16'hF101; exp_w[2] = 16'hF210;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_v   = (e >= 4) && ((e - 4) % 3 == 0);
      exp_ain = (e < 4) ? 16'h0 : 16'((e - 1) / 3);
      checks++;
      if ({instr_valid, ain, oen} !== {exp_v, exp_ain, 1'b0}) begin
        errors++;
        $display("FAIL %s edge %0d: valid/ain/oen got %b/%h/%b expected %b/%h/%b",
                 name, e, instr_valid, ain, oen, exp_v, exp_ain, 1'b0);
      end
      if (exp_v) begin
        exp_i = exp_w[(e - 4) / 3];
        exp_p = 16'((e - 4) / 3);
        checks++;
        if ({instr, instr_pc} !== {exp_i, exp_p}) begin
          errors++;
          $display("FAIL %s edge %0d word: got %h@%h expected %h@%h",
                   name, e, instr, instr_pc, exp_i, exp_p);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    branch_en = 1'b0;
    branch_target = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ain, oen, instr_valid, instr, instr_pc} !== {16'h0, 1'b1, 1'b0, 16'h0, 16'h0}) begin
        errors++;
        $display("FAIL reset cycle %0d: ain=%h oen=%b valid=%b instr=%h pc=%h expected 0000/1/0/0000/0000",
                 i, ain, oen, instr_valid, instr, instr_pc);
      end
    end
  endtask

  task automatic test_streaming();
    restart(1'b1);
    check_stream("stream");
  endtask

  task automatic test_backpressure();
    restart(1'b0);
    repeat (3) tick();
    for (int e = 4; e <= 9; e++) begin
      tick();
      checks++;
      if ({instr_valid, instr, instr_pc, ain, oen} !== {1'b1, 16'hF000, 16'h0000, 16'h0001, 1'b0}) begin
        errors++;
        $display("FAIL backpressure edge %0d: valid=%b instr=%h pc=%h ain=%h oen=%b expected 1/F000/0000/0001/0",
                 e, instr_valid, instr, instr_pc, ain, oen);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc, ain} !== {1'b1, 16'hF101, 16'h0001, 16'h0002}) begin
      errors++;
      $display("FAIL hold_release: valid=%b instr=%h pc=%h ain=%h expected 1/F101/0001/0002",
               instr_valid, instr, instr_pc, ain);
    end
  endtask

  // Branch mid-access, then branch on a capture edge; continues into the wrap case.
  task automatic test_branch();
    restart(1'b0);
    repeat (5) tick();
    branch_en = 1'b1;
    branch_target = 16'h0005;
    tick();
    branch_en = 1'b0;
    checks++;
    if ({instr_valid, ain, oen} !== {1'b0, 16'h0005, 1'b0}) begin
      errors++;
      $display("FAIL branch_flush: valid=%b ain=%h oen=%b expected 0/0005/0", instr_valid, ain, oen);
    end
    repeat (2) tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_wait: valid=%b expected 0", instr_valid);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc, ain} !== {1'b1, 16'hE1FE, 16'h0005, 16'h0006}) begin
      errors++;
      $display("FAIL branch_target_word: valid=%b instr=%h pc=%h ain=%h expected 1/E1FE/0005/0006",
               instr_valid, instr, instr_pc, ain);
    end
    instr_ready = 1'b1;
    repeat (2) tick();
    branch_en = 1'b1;
    branch_target = 16'h0020;
    tick();
    branch_en = 1'b0;
    checks++;
    if ({instr_valid, instr, ain} !== {1'b0, 16'hE1FE, 16'h0020}) begin
      errors++;
      $display("FAIL branch_suppress: valid=%b instr=%h ain=%h expected 0/E1FE/0020",
               instr_valid, instr, ain);
    end
    repeat (2) tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_suppress_wait: valid=%b expected 0", instr_valid);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, mem[16'h0020], 16'h0020}) begin
      errors++;
      $display("FAIL branch2_word: valid=%b instr=%h pc=%h expected 1/%h/0020",
               instr_valid, instr, instr_pc, mem[16'h0020]);
    end
  endtask

  task automatic test_wrap();
    branch_en = 1'b1;
    branch_target = 16'hFFFF;
    tick();
    branch_en = 1'b0;
    checks++;
    if ({instr_valid, ain} !== {1'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_branch: valid=%b ain=%h expected 0/FFFF", instr_valid, ain);
    end
    repeat (3) tick();
    checks++;
    if ({instr_valid, instr, instr_pc, ain} !== {1'b1, 16'h7020, 16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_top: valid=%b instr=%h pc=%h ain=%h expected 1/7020/FFFF/0000",
               instr_valid, instr, instr_pc, ain);
    end
    repeat (3) tick();
    checks++;
    if ({instr_valid, instr, instr_pc, ain} !== {1'b1, 16'hF000, 16'h0000, 16'h0001}) begin
      errors++;
      $display("FAIL wrap_zero: valid=%b instr=%h pc=%h ain=%h expected 1/F000/0000/0001",
               instr_valid, instr, instr_pc, ain);
    end
  endtask

  task automatic test_reset_hold();
    restart(1'b0);
    repeat (8) tick();
    checks++;
    if ({instr_valid, ain, oen} !== {1'b1, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset_hold: valid=%b ain=%h oen=%b expected 1/0001/0", instr_valid, ain, oen);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc, ain, oen} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: valid=%b instr=%h pc=%h ain=%h oen=%b expected 0/0000/0000/0000/1",
               instr_valid, instr, instr_pc, ain, oen);
    end
    tick();
    instr_ready = 1'b1;
    rst_n = 1'b1;
    check_stream("restream");
  endtask

  // Scoreboard: accepted words must follow the program order implied by
  // sequential fetch and branch redirects, each matching PROM contents.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] prev_i;
    logic [15:0] prev_p;
    logic [15:0] t;
    logic        hold_prev;
    logic        r;
    logic        b;
    int          invalid_run;
    int          n_xfer;
    for (int i = 0; i < 256; i++) mem[16'(i)] = 16'($urandom);
    restart(1'b0);
    exp_pc = 16'h0000;
    hold_prev = 1'b0;
    prev_i = '0;
    prev_p = '0;
    invalid_run = 0;
    n_xfer = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_prev) begin
        checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, prev_i, prev_p}) begin
          errors++;
          $display("FAIL rand_stable cyc %0d: got %b/%h@%h expected 1/%h@%h",
                   c, instr_valid, instr, instr_pc, prev_i, prev_p);
        end
      end
      invalid_run = instr_valid ? 0 : invalid_run + 1;
      checks++;
      if (invalid_run > int'(W) + 1) begin
        errors++;
        $display("FAIL rand_starve cyc %0d: invalid for %0d cycles expected at most %0d",
                 c, invalid_run, W + 1);
      end
      r = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                      : 16'($urandom_range(0, 255));
      instr_ready = r;
      branch_en = b;
      branch_target = t;
      if (instr_valid && r) begin
        checks++;
        if ({instr_pc, instr} !== {exp_pc, mem[exp_pc]}) begin
          errors++;
          $display("FAIL rand_xfer cyc %0d: got %h@%h expected %h@%h",
                   c, instr, instr_pc, mem[exp_pc], exp_pc);
        end
        exp_pc = exp_pc + 16'd1;
        n_xfer++;
      end
      if (b) begin
        exp_pc = t;
        invalid_run = 0;
      end
      hold_prev = instr_valid && !r && !b;
      prev_i = instr;
      prev_p = instr_pc;
      tick();
    end
    branch_en = 1'b0;
    checks++;
    if (n_xfer < 300) begin
      errors++;
      $display("FAIL rand_throughput: got %0d transfers expected at least 300", n_xfer);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'hF000;
    mem[16'h0001] = 16'hF101;
    mem[16'h0002] = 16'hF210;
    mem[16'h0005] = 16'hE1FE;
    mem[16'hFFFF] = 16'h7020;
    test_reset();
    test_streaming();
    test_backpressure();
    test_branch();
    test_wrap();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 16-bit instruction PROM.
- Holds the program counter and drives the PROM address and output-enable.
- Waits a fixed number of clocks to cover PROM access time, then captures the instruction word into a one-entry output register.
- Presents the word to the decoder with a valid/ready handshake and supports branch redirect with flush.

Parameters:
- WAIT_CYCLES, 3, clocks from address drive to data sample; must be >= 1. 3 covers a 45 ns access at a 20 ns clock.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ain  output  16  PROM address
- oen  output  1  PROM output enable, active low
- din  input  16  PROM data
- instr  output  16  captured instruction word
- instr_pc  output  16  address instr was fetched from
- instr_valid  output  1  instr/instr_pc hold a valid word
- instr_ready  input  1  decoder accepts the word this cycle
- branch_en  input  1  single-cycle redirect request
- branch_target  input  16  new PC, sampled when branch_en=1

Behaviour:
- Reset is asynchronous. While rst_n=0:
  - state=IDLE, pc=RESET_PC, ain=RESET_PC, oen=1, cnt=0.
  - instr=0, instr_pc=0, instr_valid=0.
- Handshake: a transfer occurs on an edge where instr_valid=1 and instr_ready=1. instr/instr_pc stay stable while instr_valid=1 and instr_ready=0.
- IDLE: oen=1. Next edge: ACCESS, ain<=pc, cnt<=WAIT_CYCLES-1.
- ACCESS: oen=0, ain=pc.
  - cnt>0: cnt decrements.
  - cnt=0 and slot free (instr_valid=0, or transfer this edge): capture occurs. instr<=din, instr_pc<=pc, instr_valid<=1, pc<=pc+1, ain<=pc+1, cnt<=WAIT_CYCLES-1, remain in ACCESS.
  - cnt=0 and slot full with no transfer: go to HOLD.
- HOLD: oen=0, ain unchanged. Capture on the first edge the slot frees, same updates as ACCESS capture, return to ACCESS. No re-wait is needed because the address was stable throughout.
- Transfer without capture on the same edge: instr_valid<=0.
- PC arithmetic: 16-bit modulo, so 16'hFFFF+1 = 16'h0000. No fault on wrap.
- Throughput: one word per WAIT_CYCLES clocks with no backpressure.
- First-word latency: instr_valid rises on edge WAIT_CYCLES+1 after the first edge with rst_n=1 (edge 1 is IDLE to ACCESS).
- branch_en=1 at an edge, from any state:
  - pc<=branch_target, ain<=branch_target, instr_valid<=0. Any in-flight access is abandoned and any capture due that edge is suppressed.
  - state<=ACCESS, cnt<=WAIT_CYCLES-1.
  - branch_en has priority over capture.
  - If a transfer also occurs on that edge, the decoder consumes the old word normally and the flush applies afterwards.
- oen stays 0 across branch and sequential address changes. Only IDLE deasserts oen.
- branch_en in IDLE: PC redirects and IDLE exits to ACCESS as normal.
- Reset asserted mid-access or in HOLD: immediate return to reset values; the next fetch restarts at RESET_PC.
- instr_ready while instr_valid=0 is ignored.

Test Plan:
1. Reset: with W=3, hold rst_n=0 for 5 clocks -> ain=0000, oen=1, instr_valid=0, instr=0, all stable.
2. Streaming: PROM model mem[0..2]=F000,F101,F210, instr_ready=1 tied, release reset.
   - Valid first appears at edge 4 with instr=F000, instr_pc=0000.
   - F101 at edge 7, F210 at edge 10.
   - ain steps 0,1,2,3.
3. Backpressure: instr_ready=0 from edge 4 for 6 clocks.
   - instr stays F000.
   - HOLD is entered with ain=0001, oen=0.
   - After instr_ready=1, the next edge transfers F000 and captures F101 with no extra wait.
4. Branch: assert branch_en with target=0005 mid-ACCESS while a word is valid.
   - instr_valid=0 next cycle, ain=0005.
   - mem[5]=E1FE appears 3 edges later with instr_pc=0005.
   - Also branch on the same edge as a capture -> the capture is suppressed.
5. Wrap: branch to FFFF, mem[FFFF]=7020, mem[0]=F000 -> 7020 with instr_pc=FFFF, then F000 with instr_pc=0000.
6. Reset mid-HOLD: assert rst_n=0 asynchronously between edges.
   - Outputs clear immediately, oen=1.
   - After release, the sequence matches scenario 2.
